alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
Multi-cycle sequencer that performs a 64-bit unsigned/two's-complement MUL (low 64 bits of the product) by driving the shared 64-bit ALU in shift-add fashion. It sits beside the ALU in the execute stage and owns the ALU operand and control inputs while busy. The parent muxes ALU inputs on `busy`. It issues one ALU add per iteration and holds the product until the next operation.

Parameters:
- WIDTH, 64, operand/product width; the ALU is 64-bit, so only 64 is supported.
- CNT_W, 7, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- mcand  in  64  multiplicand, sampled with start
- mplier  in  64  multiplier, sampled with start
- busy  out  1  operation in progress; the block owns the ALU
- done  out  1  one-cycle pulse; product valid
- product  out  64  low 64 bits of mcand*mplier; held until next done
- alu_a  out  64  ALU operand A (accumulator)
- alu_b  out  64  ALU operand B (gated multiplicand)
- alu_cntrl  out  3  ALU operation select
- alu_result  in  64  ALU result, combinational return

Behaviour:
- Reset (reset_n=0, async): state=IDLE; busy=0, done=0, product=0, alu_a=0, alu_b=0, alu_cntrl=3'b000. All internal registers (acc, mc_reg, mp_reg, cnt) are 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1: load acc=0, mc_reg=mcand, mp_reg=mplier, cnt=0; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, ALU drive (combinational from registers):
  - alu_a=acc
  - alu_b = mp_reg[0] ? mc_reg : 0
  - alu_cntrl=3'b010 (add)
- RUN, each clock edge:
  - acc<=alu_result
  - mc_reg<=mc_reg<<1, zero fill
  - mp_reg<=mp_reg>>1, zero fill
  - cnt<=cnt+1
- RUN exit: when cnt==WIDTH-1 at the edge, go to DONE and load product<=alu_result.
- DONE: lasts exactly one cycle with done=1 and busy=0; then go to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE: load registers and go to RUN, so back-to-back operations are supported.
- busy=1 exactly while state==RUN. start while busy=1 is ignored, and mcand/mplier are not resampled.
- Outside RUN: alu_a=0, alu_b=0, alu_cntrl=3'b000.
- Latency: start high at cycle 0 → RUN in cycles 1..64 → done high in cycle 65. product is stable from cycle 65 onward.
- Arithmetic:
  - Carry out of the ALU and product bits above 63 are discarded. The result equals the low 64 bits of the product, for signed and unsigned operands alike.
  - Bits shifted out of mc_reg are lost.
- Reset mid-operation: immediately returns to IDLE with all outputs at reset values. The partial result is discarded and product is cleared to 0.
- product is not modified except at RUN→DONE and on reset.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined:
  - RUN also exits to DONE at any edge where the next mp_reg (mp_reg>>1) is 0; product<=alu_result at that edge.
  - RUN cycles = max(1, msb_index(mplier)+1).
  - mplier=0 gives 1 RUN cycle; done is at cycle 2 and product=0.
- Undefined: RUN always lasts exactly WIDTH (64) cycles regardless of operands.
- Results are identical in both builds; only latency differs.

Test Plan:
- Basic multiply: reset, then start with mcand=3, mplier=5 → busy=1 in cycles 1..64; done=1 only in cycle 65; product=15. With MUL_EARLY_TERM_EN: done in cycle 4, product=15.
- Wrap-around: mcand=mplier=0xFFFF_FFFF_FFFF_FFFF → product=0x0000_0000_0000_0001. Then mcand=0x8000_0000_0000_0000, mplier=2 → product=0.
- Zero operand: mplier=0, mcand=0x1234 → product=0; done at cycle 65, or at cycle 2 with MUL_EARLY_TERM_EN.
- Start while busy: start 7×6, then pulse start with 9×9 at cycle 10 → ignored; product=42 at cycle 65. Start 9×9 asserted during the DONE cycle → accepted; product=81 exactly 65 cycles later.
- Reset mid-run: start 3×5, assert reset_n=0 at cycle 30 → busy=0, done=0, product=0 immediately, alu_cntrl=3'b000. After release, start 2×4 → product=8 with normal latency.
- ALU drive check: during RUN of mcand=1, mplier=0b101 → alu_cntrl=3'b010 each RUN cycle; alu_b=1, 0, 4 in cycles 1..3 and 0 afterwards. Outside RUN, alu_a=alu_b=0.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Shift-add 64-bit multiplier sequencer that borrows the shared execute-stage ALU while busy.
// Optional build macro MUL_EARLY_TERM_EN: stop iterating once the remaining multiplier bits are zero.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cntrl,
   input  logic [WIDTH-1:0] alu_result
);

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_IDLE = 3'b000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mc_q, mc_d;
   logic [WIDTH-1:0] mp_q, mp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] product_q, product_d;
   logic [WIDTH-1:0] mp_shift;
   logic             last_iter;

   assign mp_shift = mp_q >> 1;

`ifdef MUL_EARLY_TERM_EN
   // Remaining multiplier bits all zero means every later add would contribute nothing.
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (mp_shift == '0);
`else
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mc_d      = mc_q;
      mp_d      = mp_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      busy      = 1'b0;
      done      = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_cntrl = ALU_IDLE;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            done = (state_q == S_DONE);
            // DONE accepts start exactly like IDLE so operations can run back to back.
            if (start) begin
               acc_d   = '0;
               mc_d    = mcand;
               mp_d    = mplier;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            busy      = 1'b1;
            alu_a     = acc_q;
            alu_b     = mp_q[0] ? mc_q : '0;
            alu_cntrl = ALU_ADD;
            acc_d     = alu_result;
            mc_d      = mc_q << 1;
            mp_d      = mp_shift;
            cnt_d     = cnt_q + CNT_W'(1);
            if (last_iter) begin
               state_d   = S_DONE;
               product_d = alu_result;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mc_q      <= '0;
         mp_q      <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mc_q      <= mc_d;
         mp_q      <= mp_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural ALU; honours MUL_EARLY_TERM_EN when defined.
module tb_alu_mul_seq;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [63:0] mcand;
   logic [63:0] mplier;
   logic        busy;
   logic        done;
   logic [63:0] product;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [2:0]  alu_cntrl;
   logic [63:0] alu_result;

   typedef struct {
      logic [63:0] prod;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cyc;
   int unsigned total;
   int unsigned bad;

   alu_mul_seq #(.WIDTH(64), .CNT_W(7)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .mcand      (mcand),
      .mplier     (mplier),
      .busy       (busy),
      .done       (done),
      .product    (product),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cntrl  (alu_cntrl),
      .alu_result (alu_result)
   );

   // Shared execute-stage ALU: only add is exercised by this block.
   assign alu_result = (alu_cntrl == 3'b010) ? alu_a + alu_b : 64'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%016h expected=0x%016h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int unsigned lat(input logic [63:0] mp);
`ifdef MUL_EARLY_TERM_EN
      int unsigned run = 1;
      for (int i = 0; i < 64; i++)
         if (mp[i]) run = i + 1;
      return run + 1;
`else
      return 65;
`endif
   endfunction

   // Called at a negedge; start is sampled at the following posedge.
   task automatic issue(input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      e.prod = a * b;
      e.cyc  = cyc + lat(b);
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset_n && done) begin
         if (exp_q.size() == 0) begin
            chk("spurious_done", 64'(done), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("product", product, e.prod);
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned busy_cnt;
      int unsigned run;
      int unsigned ign;
      logic [63:0] acc;
      logic [63:0] expb;
      logic [63:0] mpv;
      logic [63:0] mp_rst;

      total   = 0;
      bad     = 0;
      reset_n = 1'b0;
      start   = 1'b0;
      mcand   = '0;
      mplier  = '0;
      repeat (3) @(negedge clk);

      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_product", product, 64'd0);
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_alu_b", alu_b, 64'd0);
      chk("rst_alu_cntrl", 64'(alu_cntrl), 64'd0);

      reset_n = 1'b1;
      @(negedge clk);

      // Basic 3x5 with busy window length.
      issue(64'd3, 64'd5);
      busy_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         busy_cnt++;
         @(negedge clk);
      end
      chk("busy_cycles", 64'(busy_cnt), 64'(lat(64'd5) - 1));
      chk("done_after_busy", 64'(done), 64'd1);
      drain();

      // ALU drive pattern for 1 x 0b101.
      mpv = 64'd5;
      issue(64'd1, mpv);
      run = lat(mpv) - 1;
      acc = '0;
      for (int i = 0; i < 64; i++) begin
         if (i >= run) break;
         expb = mpv[i] ? (64'd1 << i) : 64'd0;
         chk("drv_cntrl", 64'(alu_cntrl), 64'd2);
         chk("drv_alu_b", alu_b, expb);
         chk("drv_alu_a", alu_a, acc);
         acc = acc + expb;
         @(negedge clk);
      end
      chk("idle_alu_a", alu_a, 64'd0);
      chk("idle_alu_b", alu_b, 64'd0);
      chk("idle_cntrl", 64'(alu_cntrl), 64'd0);
      drain();

      // Wrap-around and zero operand.
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      drain();
      issue(64'h8000_0000_0000_0000, 64'd2);
      drain();
      issue(64'h1234, 64'd0);
      drain();
      issue(64'hDEAD_BEEF_0123_4567, 64'h0000_0001_FEDC_BA98);
      drain();

      // Start while busy is ignored; start during DONE is accepted.
`ifdef MUL_EARLY_TERM_EN
      ign = 2;
`else
      ign = 10;
`endif
      issue(64'd7, 64'd6);
      repeat (ign - 1) @(negedge clk);
      start  = 1'b1;
      mcand  = 64'd9;
      mplier = 64'd9;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done) break;
         @(negedge clk);
      end
      chk("wait_done", 64'(done), 64'd1);
      if (done) issue(64'd9, 64'd9);
      drain();

      // Asynchronous reset mid-run.
`ifdef MUL_EARLY_TERM_EN
      mp_rst = 64'h8000_0000_0000_0005;
`else
      mp_rst = 64'd5;
`endif
      issue(64'd3, mp_rst);
      repeat (29) @(negedge clk);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_product", product, 64'd0);
      chk("midrst_cntrl", 64'(alu_cntrl), 64'd0);
      chk("midrst_alu_a", alu_a, 64'd0);
      chk("midrst_alu_b", alu_b, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      issue(64'd2, 64'd4);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
